gate_bist: RTL and testbench
============================

GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter N_IN, default 2: DUT gate input width; legal range 1..16.
REQ-002 Parameter WAIT_CYCLES, default 1: settle cycles per vector before sampling; legal range 1..255.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active high.
REQ-006 start  input  1  run request; sampled only in IDLE or DONE.
REQ-007 mode  input  2  gate function under test: 0 AND, 1 OR, 2 XOR, 3 NAND (reduction over all N_IN bits).
REQ-008 dut_y  input  1  DUT output.
REQ-009 vec_out  output  N_IN  stimulus vector driven to the DUT inputs.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  valid when done; high when err_count is 0.
REQ-013 err_count  output  N_IN+1  number of mismatching vectors in the current or last run.
REQ-014 first_fail_vec  output  N_IN  first vector that mismatched.
REQ-015 first_fail_valid  output  1  high once first_fail_vec holds a recorded failure.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, CHECK and DONE.
REQ-017 IDLE or DONE with start=1 SHALL do the following at that edge:
  - go to SETTLE;
  - clear vec_out, err_count and first_fail_valid;
  - latch mode;
  - load the settle counter with WAIT_CYCLES-1.
REQ-018 In IDLE or DONE with start=0, the state and all outputs SHALL hold.
REQ-019 SETTLE SHALL last exactly WAIT_CYCLES cycles, decrementing the counter, then go to CHECK.
REQ-020 CHECK SHALL last one cycle and compare dut_y against the reference function of vec_out under the latched mode.
REQ-021 On a mismatch in CHECK, err_count SHALL increment by 1; no saturation is needed because the width N_IN+1 holds 2^N_IN.
REQ-022 On the first mismatch of a run, CHECK SHALL capture vec_out into first_fail_vec and set first_fail_valid.
  - Later mismatches SHALL NOT overwrite either.
REQ-023 In CHECK with vec_out not all ones, vec_out SHALL increment by 1, the counter SHALL reload, and the FSM SHALL go to SETTLE.
REQ-024 In CHECK with vec_out all ones, the FSM SHALL go to DONE with vec_out held.
  - There is no wrap to 0.
REQ-025 Latency: done SHALL rise exactly 1 + 2^N_IN*(WAIT_CYCLES+1) cycles after the start edge.
REQ-026 busy SHALL be high in SETTLE and CHECK; done SHALL be high only in DONE.
  - busy and done SHALL never both be high.
REQ-027 pass SHALL equal (done AND err_count==0); pass is 0 outside DONE.
REQ-028 While busy, start SHALL be ignored, and changes on mode SHALL have no effect on the run in progress.
REQ-029 A start in DONE SHALL restart a run identically to REQ-017, with the previous results cleared.
REQ-030 dut_y SHALL be sampled only in CHECK; its value in any other state SHALL be ignored.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE in every state, including mid-run.
REQ-032 That edge SHALL zero vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid, the settle counter and the latched mode.
REQ-033 rst SHALL take priority over start at the same edge.
REQ-034 Reset SHALL have no asynchronous effect.
  - Outputs are unknown before the first reset edge.

Verification
REQ-035 Correct AND DUT; N_IN=2, WAIT_CYCLES=1, mode=0; start for one cycle:
  - vec_out steps 00,01,10,11, each held 2 cycles;
  - done rises 9 cycles after start;
  - pass=1, err_count=0, first_fail_valid=0.
REQ-036 AND DUT stuck-at-0, mode=0, N_IN=2:
  - err_count=1, first_fail_vec=2'b11, first_fail_valid=1, pass=0.
REQ-037 Correct AND DUT with mode=2 (XOR), N_IN=2:
  - err_count=3, first_fail_vec=2'b01, pass=0.
REQ-038 N_IN=4, WAIT_CYCLES=3, mode=3 (NAND), DUT stuck-at-1:
  - done rises 65 cycles after start;
  - err_count=1, first_fail_vec=4'hF.
REQ-039 rst asserted at vec_out=2'b10 mid-run:
  - the next cycle shows IDLE with all outputs zero;
  - a following start runs to pass=1 with a correct DUT.
REQ-040 start pulsed and mode toggled while busy:
  - both are ignored;
  - the results match REQ-035;
  - a start in DONE restarts and clears err_count on the next edge.

Source files
------------

// File: rtl/gate_bist_if.sv
// Handshake and result bundle between the gate BIST controller and its driver.
// The controller takes the slave side; the tester or bench takes the master side.
interface gate_bist_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [1:0]      mode;
  logic            dut_y;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;

  modport master (
    output start, mode, dut_y,
    input  vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, mode, dut_y,
    output vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_bist.sv
// Exhaustive BIST for an N_IN-input reduction gate: walk every input vector,
// let it settle, compare the gate output against AND/OR/XOR/NAND, log mismatches.
module gate_bist #(
  parameter int N_IN        = 2,
  parameter int WAIT_CYCLES = 1
) (
  input logic        clk,
  input logic        rst,
  gate_bist_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0] RELOAD = 8'(WAIT_CYCLES - 1);

  state_t          state;
  logic [7:0]      cnt;
  logic [1:0]      mode_q;
  logic [N_IN-1:0] vec;
  logic [N_IN:0]   err;
  logic [N_IN-1:0] ffv;
  logic            ffvalid;
  logic            busy, done, pass;
  logic            ref_y, mismatch;

  // Reference uses the mode latched at start so mid-run mode changes are inert.
  always_comb begin
    ref_y = 1'b0;
    case (mode_q)
      2'd0:    ref_y = &vec;
      2'd1:    ref_y = |vec;
      2'd2:    ref_y = ^vec;
      default: ref_y = ~&vec;
    endcase
  end

  assign mismatch = (bus.dut_y != ref_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_q  <= '0;
      vec     <= '0;
      err     <= '0;
      ffv     <= '0;
      ffvalid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= SETTLE;
            vec     <= '0;
            err     <= '0;
            ffvalid <= 1'b0;
            mode_q  <= bus.mode;
            cnt     <= RELOAD;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) state <= CHECK;
          else             cnt   <= cnt - 8'd1;
        end
        CHECK: begin
          if (mismatch) begin
            err <= err + (N_IN+1)'(1);
            if (!ffvalid) begin
              ffv     <= vec;
              ffvalid <= 1'b1;
            end
          end
          if (vec != '1) begin
            vec   <= vec + N_IN'(1);
            cnt   <= RELOAD;
            state <= SETTLE;
          end else begin
            // Final vector: pass must account for this cycle's compare too.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vec_out          = vec;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.err_count        = err;
  assign bus.first_fail_vec   = ffv;
  assign bus.first_fail_valid = ffvalid;
endmodule

// File: tb/tb_gate_bist.sv
// Directed and random runs of gate_bist with the gate under test emulated as a truth table;
// expected results come from a vector-by-vector model of the gate functions.
module tb_gate_bist;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_bist_if #(.N_IN(2)) bus_a ();
  gate_bist_if #(.N_IN(4)) bus_b ();

  gate_bist #(.N_IN(2), .WAIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  gate_bist #(.N_IN(4), .WAIT_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [15:0] tbl_a, tbl_b;
  assign bus_a.dut_y = tbl_a[bus_a.vec_out];
  assign bus_b.dut_y = tbl_b[bus_b.vec_out];

  int n_assert = 0;
  int n_fail   = 0;
  int ffv_a    = 0;
  int ffv_b    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int n, input logic [1:0] m, input logic [15:0] tbl,
                                output int errs, output int ffv, output bit ffok);
    bit g;
    int all;
    all  = (1 << n) - 1;
    errs = 0; ffv = 0; ffok = 0;
    for (int v = 0; v <= all; v++) begin
      case (m)
        2'd0:    g = (v == all);
        2'd1:    g = (v != 0);
        2'd2:    g = ($countones(v) % 2) == 1;
        default: g = (v != all);
      endcase
      if (tbl[v] != g) begin
        errs++;
        if (!ffok) begin ffok = 1; ffv = v; end
      end
    end
  endfunction

  task automatic run_a(input logic [1:0] m, input logic [15:0] tbl, input bit perturb);
    int errs, ffv, cyc;
    bit ffok;
    model(2, m, tbl, errs, ffv, ffok);
    if (ffok) ffv_a = ffv;
    tbl_a = tbl; bus_a.mode = m; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    chk("a_clear_err", 32'(bus_a.err_count), 0);
    chk("a_clear_ffvalid", 32'(bus_a.first_fail_valid), 0);
    cyc = 1;
    while (!bus_a.done && cyc < 40) begin
      chk("a_busy", 32'(bus_a.busy), 1);
      chk("a_vec", 32'(bus_a.vec_out), 32'((cyc - 1) / 2));
      if (perturb && cyc == 3) begin bus_a.start = 1'b1; bus_a.mode = ~m; end
      if (cyc == 4) bus_a.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("a_latency", 32'(cyc), 9);
    chk("a_busy_end", 32'(bus_a.busy), 0);
    chk("a_vec_hold", 32'(bus_a.vec_out), 3);
    chk("a_err", 32'(bus_a.err_count), 32'(errs));
    chk("a_ffvalid", 32'(bus_a.first_fail_valid), 32'(ffok));
    chk("a_ffv", 32'(bus_a.first_fail_vec), 32'(ffv_a));
    chk("a_pass", 32'(bus_a.pass), 32'(errs == 0));
    repeat (2) @(negedge clk);
    chk("a_done_hold", 32'(bus_a.done), 1);
    chk("a_err_hold", 32'(bus_a.err_count), 32'(errs));
  endtask

  task automatic run_b(input logic [1:0] m, input logic [15:0] tbl);
    int errs, ffv, cyc;
    bit ffok;
    model(4, m, tbl, errs, ffv, ffok);
    if (ffok) ffv_b = ffv;
    tbl_b = tbl; bus_b.mode = m; bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    cyc = 1;
    while (!bus_b.done && cyc < 120) begin
      chk("b_busy", 32'(bus_b.busy), 1);
      @(negedge clk);
      cyc++;
    end
    chk("b_latency", 32'(cyc), 65);
    chk("b_busy_end", 32'(bus_b.busy), 0);
    chk("b_err", 32'(bus_b.err_count), 32'(errs));
    chk("b_ffvalid", 32'(bus_b.first_fail_valid), 32'(ffok));
    chk("b_ffv", 32'(bus_b.first_fail_vec), 32'(ffv_b));
    chk("b_pass", 32'(bus_b.pass), 32'(errs == 0));
  endtask

  initial begin
    int w;
    logic [1:0] rm;
    logic [15:0] rt;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.mode = 2'd0; tbl_a = 16'h0008;
    bus_b.start = 1'b0; bus_b.mode = 2'd0; tbl_b = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_vec", 32'(bus_a.vec_out), 0);
    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_done", 32'(bus_a.done), 0);
    chk("rst_pass", 32'(bus_a.pass), 0);
    chk("rst_err", 32'(bus_a.err_count), 0);
    chk("rst_ffv", 32'(bus_a.first_fail_vec), 0);
    chk("rst_ffvalid", 32'(bus_a.first_fail_valid), 0);
    chk("rst_b_busy", 32'(bus_b.busy), 0);
    // Start alongside reset must lose to reset.
    bus_a.start = 1'b1;
    @(negedge clk);
    chk("rst_prio_busy", 32'(bus_a.busy), 0);
    bus_a.start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hold_busy", 32'(bus_a.busy), 0);
    chk("idle_hold_vec", 32'(bus_a.vec_out), 0);

    run_a(2'd0, 16'h0008, 1'b0);  // correct AND
    run_a(2'd0, 16'h0000, 1'b0);  // stuck-at-0
    run_a(2'd2, 16'h0008, 1'b0);  // AND tested as XOR
    run_a(2'd0, 16'h0008, 1'b1);  // start/mode noise while busy, restart from DONE

    // Reset mid-run at vector 2'b10.
    tbl_a = 16'h0008; bus_a.mode = 2'd0; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    w = 0;
    while (bus_a.vec_out != 2'b10 && w < 20) begin @(negedge clk); w++; end
    chk("mid_reached_10", 32'(bus_a.vec_out), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ffv_a = 0; ffv_b = 0;
    chk("mid_rst_vec", 32'(bus_a.vec_out), 0);
    chk("mid_rst_busy", 32'(bus_a.busy), 0);
    chk("mid_rst_done", 32'(bus_a.done), 0);
    chk("mid_rst_err", 32'(bus_a.err_count), 0);
    run_a(2'd0, 16'h0008, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rm = 2'($urandom_range(0, 3));
      rt = 16'($urandom);
      run_a(rm, rt, 1'b0);
    end

    run_b(2'd3, 16'hFFFF);  // NAND, stuck-at-1
    rm = 2'($urandom_range(0, 3));
    rt = 16'($urandom);
    run_b(rm, rt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
